// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone single-transfer master.
package wb_master_pkg;

  localparam int DEF_AW             = 8;
  localparam int DEF_DW             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Transfer sequencing: wait for request, run bus cycle, hold response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles from 0, flags the last allowed one.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q;

  // Count cycles while enabled; clear wins so each transfer starts at 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // High during the final allowed cycle; the master terminates on that edge.
  always_comb begin
    expired = enable && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/wb_gpio_master.sv
// Wishbone classic single-transfer master with valid/ready request and
// response channels. Optional bus watchdog enabled by WB_MASTER_TIMEOUT_EN.
module wb_gpio_master
  import wb_master_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // request channel
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_adr_i,
  input  logic [DW-1:0]   req_dat_i,
  input  logic [DW/8-1:0] req_sel_i,
  // response channel
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            rsp_timeout_o,
  // wishbone master
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  state_e state_q, state_d;
  logic   accept;
  logic   term;
  logic   tmo_exp;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state_q != ST_BUS),
    .enable  (state_q == ST_BUS),
    .expired (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus accept/terminate strobes. Slave responses only count in BUS.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    term    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i || wb_err_i || tmo_exp) begin
          term    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and bus strobes decode straight from state so cyc/stb drop on
  // the terminating edge and rise the cycle after acceptance.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) && !wb_rst_i;
    rsp_valid_o = (state_q == ST_RESP);
    wb_cyc_o    = (state_q == ST_BUS);
    wb_stb_o    = (state_q == ST_BUS);
  end

  // Capture the request at acceptance; held stable for the whole bus cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
    end else if (accept) begin
      wb_we_o  <= req_we_i;
      wb_adr_o <= req_adr_i;
      wb_dat_o <= req_dat_i;
      wb_sel_o <= req_sel_i;
    end
  end

  // Latch the response on termination; err beats ack when both arrive.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else if (term) begin
      if (wb_err_i) begin
        rsp_dat_o <= '0;
        rsp_err_o <= 1'b1;
      end else if (wb_ack_i) begin
        rsp_dat_o <= wb_we_o ? '0 : wb_dat_i;
        rsp_err_o <= 1'b0;
      end else begin
        rsp_dat_o <= '0;
        rsp_err_o <= 1'b0;
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  // Timeout flag is set only when the watchdog, not the slave, ended the cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  rsp_timeout_o <= 1'b0;
    else if (term) rsp_timeout_o <= !(wb_ack_i || wb_err_i);
  end
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: doc/wb_gpio_master.md
WB_GPIO_MASTER -- requirements
Module: wb_gpio_master

Interface
REQ-001 SHALL have parameter AW, default 8, meaning Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, meaning Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles to wait for ack/err (range 2..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 wb_clk_i  input  1  clock; all logic on rising edge.
REQ-006 wb_rst_i  input  1  synchronous active-high reset.
REQ-007 req_valid_i  input  1  request offered.
REQ-008 req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-009 req_we_i  input  1  1=write, 0=read.
REQ-010 req_adr_i  input  AW  target register address.
REQ-011 req_dat_i  input  DW  write data.
REQ-012 req_sel_i  input  DW/8  byte selects.
REQ-013 rsp_valid_o  output  1  response available.
REQ-014 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-015 rsp_dat_o  output  DW  read data (0 for writes, errors, timeouts).
REQ-016 rsp_err_o  output  1  slave returned err.
REQ-017 rsp_timeout_o  output  1  transfer aborted by timeout.
REQ-018 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master controls.
REQ-019 wb_adr_o  output  AW; wb_dat_o  output  DW; wb_sel_o  output  DW/8  Wishbone master address/data/selects.
REQ-020 wb_dat_i  input  DW; wb_ack_i, wb_err_i  input  1 each  Wishbone slave response.

Function
REQ-021 SHALL implement FSM IDLE, BUS, RESP; one transfer outstanding at a time.
REQ-022 IDLE: req_ready_o=1; on req_valid_i&req_ready_o, register we/adr/dat/sel and go BUS.
REQ-023 wb_cyc_o and wb_stb_o SHALL be asserted from the cycle after acceptance, held together, all wb_*_o stable, until termination.
REQ-024 BUS: wb_ack_i=1 terminates; rsp_dat_o<=wb_dat_i if read else 0, rsp_err_o<=0; go RESP.
REQ-025 BUS: wb_err_i=1 terminates; rsp_err_o<=1, rsp_dat_o<=0; ack and err together SHALL be treated as err.
REQ-026 wb_cyc_o/wb_stb_o SHALL deassert on the edge that samples termination; latency ack-sample -> rsp_valid_o high is 1 cycle.
REQ-027 RESP: rsp_valid_o=1, outputs held until rsp_ready_i; then IDLE; req_ready_o=0 in BUS and RESP.
REQ-028 Minimum turnaround: accept at cycle 0, stb at 1, ack at 1 -> rsp_valid_o at 2; next accept no earlier than the cycle after response handshake.
REQ-029 wb_ack_i/wb_err_i outside BUS SHALL be ignored.

Reset
REQ-030 On wb_rst_i: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o/wb_sel_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=rsp_timeout_o=0, req_ready_o=0 during reset, timeout counter=0.
REQ-031 Reset during BUS or RESP SHALL abort: cyc/stb low after the reset edge, pending response discarded, no response emitted.

Configuration
REQ-032 Macro WB_MASTER_TIMEOUT_EN: when defined, counter counts BUS cycles from 0; if no ack/err by count TIMEOUT_CYCLES-1, terminate, rsp_timeout_o=1, rsp_err_o=0, rsp_dat_o=0, go RESP.
REQ-033 Ack/err sampled in the same cycle the count reaches TIMEOUT_CYCLES-1 SHALL take priority over timeout.
REQ-034 When undefined: no counter logic, BUS waits indefinitely, rsp_timeout_o tied 0.

Structure
REQ-035 Package wb_master_pkg SHALL hold the FSM state enum, default AW/DW constants, and TIMEOUT_CYCLES default.
REQ-036 One sub-module wb_timeout_cnt (clear, enable, expired) SHALL hold the counter, instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-037 Write adr=0x04 dat=0xA5A5_0F0F sel=0xF, slave acks after 1 cycle -> one cyc/stb cycle pair with wb_we_o=1, response err=0 timeout=0 dat=0.
REQ-038 Read adr=0x00, slave returns 0x0000_00C3 with ack after 3 wait states -> rsp_dat_o=0x0000_00C3, rsp_valid_o 1 cycle after ack, wb_*_o stable throughout.
REQ-039 Slave asserts ack and err together -> rsp_err_o=1, rsp_dat_o=0.
REQ-040 WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never responds -> cyc/stb drop after 16 BUS cycles, rsp_timeout_o=1; ack on cycle 16 instead -> normal response.
REQ-041 rsp_ready_i held low 5 cycles -> rsp_valid_o and rsp_* held, req_ready_o=0, new request not accepted until handshake.
REQ-042 wb_rst_i pulsed mid-BUS -> cyc/stb low next cycle, no rsp_valid_o, next request completes normally.
